branch_predict_resolve: RTL and testbench

Parametrised branch resolution and prediction unit for the pipelined RV32I core. It evaluates all six RV32I branch conditions in Execute and keeps a table of 2-bit saturating counters that Decode reads for a taken/not-taken prediction. It drives the 2-bit PC select with mispredict recovery, and keeps saturating branch and mispredict performance counters. The unit sits between the Decode/Execute pipeline registers and the PC mux, alongside the hazard unit.

---
 rtl/branch_predict_resolve.sv | 127 ++++++++++++
 tb/tb_branch_predict_resolve.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_resolve.sv
// Branch resolution in Execute plus a 2-bit saturating-counter prediction table read in Decode.
// Drives the PC select with mispredict recovery and keeps saturating performance counters.
module branch_predict_resolve #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ENTRIES    = 64,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] PCD,
  output logic                  PredictTakenD,
  input  logic                  BranchE,
  input  logic                  JumpE,
  input  logic                  JalrE,
  input  logic [2:0]            Funct3E,
  input  logic [DATA_WIDTH-1:0] SrcAE,
  input  logic [DATA_WIDTH-1:0] SrcBE,
  input  logic [ADDR_WIDTH-1:0] PCE,
  input  logic                  PredTakenE,
  input  logic                  StallE,
  output logic [1:0]            PCSrcE,
  output logic                  MispredictE,
  output logic [CNT_WIDTH-1:0]  BranchCount,
  output logic [CNT_WIDTH-1:0]  MispredictCount
);

  localparam int unsigned IdxW = $clog2(ENTRIES);

  logic [1:0]           pht_q [ENTRIES];
  logic [IdxW-1:0]      idx_d;
  logic [IdxW-1:0]      idx_e;
  logic                 taken;
  logic                 update;
  logic [1:0]           ctr;
  logic [1:0]           ctr_d;
  logic [1:0]           pcsrc;
  logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
  logic [CNT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;
  logic                 unused_pc;

  // Word-aligned PCs: bits [1:0] and the high bits do not select a table entry.
  assign idx_d     = PCD[IdxW+1:2];
  assign idx_e     = PCE[IdxW+1:2];
  assign unused_pc = ^{PCD, PCE};

  // No bypass: a same-index update this cycle is not visible until the next one.
  assign PredictTakenD = pht_q[idx_d][1];

  always_comb begin
    taken = 1'b0;
    case (Funct3E)
      3'b000:  taken = (SrcAE == SrcBE);
      3'b001:  taken = (SrcAE != SrcBE);
      3'b100:  taken = ($signed(SrcAE) <  $signed(SrcBE));
      3'b101:  taken = ($signed(SrcAE) >= $signed(SrcBE));
      3'b110:  taken = (SrcAE <  SrcBE);
      3'b111:  taken = (SrcAE >= SrcBE);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    pcsrc = 2'b00;
    if (!StallE) begin
      if (JalrE) begin
        pcsrc = 2'b10;
      end else if (JumpE) begin
        pcsrc = 2'b01;
      end else if (BranchE && taken && !PredTakenE) begin
        pcsrc = 2'b01;
      end else if (BranchE && !taken && PredTakenE) begin
        pcsrc = 2'b11;
      end
    end
  end

  assign PCSrcE      = pcsrc;
  assign MispredictE = |pcsrc;

  // A jump alongside BranchE wins, and a held branch is only counted once it leaves the stall.
  assign update = BranchE && !StallE && !JumpE && !JalrE;
  assign ctr    = pht_q[idx_e];

  always_comb begin
    ctr_d = ctr;
    if (taken) begin
      if (ctr != 2'b11) ctr_d = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) ctr_d = ctr - 2'd1;
    end
  end

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (update) begin
      if (!(&branch_count_q)) branch_count_d = branch_count_q + CNT_WIDTH'(1);
      // Only 01 and 11 are reachable on the branch path.
      if (pcsrc[0] && !(&mispredict_count_q)) begin
        mispredict_count_d = mispredict_count_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) pht_q[i] <= 2'b01;
    end else if (update) begin
      pht_q[idx_e] <= ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign BranchCount     = branch_count_q;
  assign MispredictCount = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed bench for branch_predict_resolve: combinational vector table plus multi-cycle sequences.
// A second instance with 4-bit performance counters shares all inputs for the saturation check.
module tb_branch_predict_resolve;

  logic        clk;
  logic        rst;
  logic [31:0] PCD, PCE, SrcAE, SrcBE;
  logic        BranchE, JumpE, JalrE, PredTakenE, StallE;
  logic [2:0]  Funct3E;

  logic        PredictTakenD, MispredictE;
  logic [1:0]  PCSrcE;
  logic [15:0] BranchCount, MispredictCount;

  logic        PredictTakenD4, MispredictE4;
  logic [1:0]  PCSrcE4;
  logic [3:0]  BranchCount4, MispredictCount4;

  int nvec  = 0;
  int nfail = 0;

  branch_predict_resolve dut (
    .clk(clk), .rst(rst), .PCD(PCD), .PredictTakenD(PredictTakenD),
    .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE), .Funct3E(Funct3E),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .PCE(PCE), .PredTakenE(PredTakenE), .StallE(StallE),
    .PCSrcE(PCSrcE), .MispredictE(MispredictE),
    .BranchCount(BranchCount), .MispredictCount(MispredictCount)
  );

  branch_predict_resolve #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .PCD(PCD), .PredictTakenD(PredictTakenD4),
    .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE), .Funct3E(Funct3E),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .PCE(PCE), .PredTakenE(PredTakenE), .StallE(StallE),
    .PCSrcE(PCSrcE4), .MispredictE(MispredictE4),
    .BranchCount(BranchCount4), .MispredictCount(MispredictCount4)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic        br, jmp, jalr, pt, stall;
    logic [1:0]  exp_pcsrc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic br, input logic jmp, input logic jalr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] pce,
                       input logic pt, input logic stall);
    BranchE = br; JumpE = jmp; JalrE = jalr; Funct3E = f3;
    SrcAE = a; SrcBE = b; PCE = pce; PredTakenE = pt; StallE = stall;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  vec_t vecs [15];

  initial begin
    // f3 a b br jmp jalr pt stall exp
    vecs[0]  = '{3'b100, 32'hFFFF_FFFF, 32'h1, 1, 0, 0, 0, 0, 2'b01}; // BLT taken
    vecs[1]  = '{3'b110, 32'hFFFF_FFFF, 32'h1, 1, 0, 0, 0, 0, 2'b00}; // BLTU not
    vecs[2]  = '{3'b101, 32'hFFFF_FFFF, 32'h1, 1, 0, 0, 0, 0, 2'b00}; // BGE not
    vecs[3]  = '{3'b111, 32'hFFFF_FFFF, 32'h1, 1, 0, 0, 0, 0, 2'b01}; // BGEU taken
    vecs[4]  = '{3'b001, 32'hFFFF_FFFF, 32'h1, 1, 0, 0, 0, 0, 2'b01}; // BNE taken
    vecs[5]  = '{3'b010, 32'hFFFF_FFFF, 32'h1, 1, 0, 0, 0, 0, 2'b00};
    vecs[6]  = '{3'b011, 32'h0,         32'h0, 1, 0, 0, 0, 0, 2'b00};
    vecs[7]  = '{3'b000, 32'hFFFF_FFFF, 32'h1, 1, 0, 0, 0, 0, 2'b00}; // BEQ not
    vecs[8]  = '{3'b000, 32'h0,         32'h0, 1, 1, 1, 0, 0, 2'b10}; // JALR wins
    vecs[9]  = '{3'b000, 32'h0,         32'h1, 0, 1, 0, 0, 0, 2'b01}; // JAL
    vecs[10] = '{3'b000, 32'h0,         32'h0, 1, 0, 0, 0, 1, 2'b00}; // stalled
    vecs[11] = '{3'b000, 32'h0,         32'h0, 1, 0, 0, 1, 0, 2'b00}; // correct taken
    vecs[12] = '{3'b000, 32'h1,         32'h0, 1, 0, 0, 1, 0, 2'b11}; // recovery
    vecs[13] = '{3'b000, 32'h0,         32'h0, 0, 0, 0, 1, 0, 2'b00};
    vecs[14] = '{3'b000, 32'h0,         32'h0, 0, 0, 1, 0, 1, 2'b00}; // stalled JALR

    rst = 1'b1;
    PCD = 32'h100;
    idle();
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_predict", {31'b0, PredictTakenD}, 32'd0);
    check("rst_bcount", {16'b0, BranchCount}, 32'd0);
    check("rst_mcount", {16'b0, MispredictCount}, 32'd0);
    check("rst_pcsrc", {30'b0, PCSrcE}, 32'd0);
    check("rst_mispred", {31'b0, MispredictE}, 32'd0);

    // BEQ taken, predicted not-taken: counter 01 -> 10
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd5, 32'd5, 32'h100, 1'b0, 1'b0);
    #1;
    check("beq_pcsrc", {30'b0, PCSrcE}, 32'd1);
    check("beq_mispred", {31'b0, MispredictE}, 32'd1);
    step();
    idle();
    #1;
    check("beq_predict", {31'b0, PredictTakenD}, 32'd1);
    check("beq_mcount", {16'b0, MispredictCount}, 32'd1);
    check("beq_bcount", {16'b0, BranchCount}, 32'd1);

    // Three correctly-predicted taken: 10 -> 11 -> 11 -> 11
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd5, 32'd5, 32'h100, 1'b1, 1'b0);
      #1;
      check("sat_pcsrc", {30'b0, PCSrcE}, 32'd0);
      step();
      idle();
      #1;
      check("sat_predict", {31'b0, PredictTakenD}, 32'd1);
    end

    // Two not-taken with taken prediction: 11 -> 10 -> 01
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd5, 32'd6, 32'h100, 1'b1, 1'b0);
    #1;
    check("nt1_pcsrc", {30'b0, PCSrcE}, 32'd3);
    step();
    #1;
    check("nt1_predict", {31'b0, PredictTakenD}, 32'd1);
    check("nt2_pcsrc", {30'b0, PCSrcE}, 32'd3);
    step();
    idle();
    #1;
    check("nt2_predict", {31'b0, PredictTakenD}, 32'd0);
    check("nt_bcount", {16'b0, BranchCount}, 32'd6);
    check("nt_mcount", {16'b0, MispredictCount}, 32'd3);

    // Combinational vector table, applied between edges
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].br, vecs[i].jmp, vecs[i].jalr, vecs[i].f3, vecs[i].a, vecs[i].b,
            32'h100, vecs[i].pt, vecs[i].stall);
      #1;
      check($sformatf("vec%0d_pcsrc", i), {30'b0, PCSrcE}, {30'b0, vecs[i].exp_pcsrc});
      check($sformatf("vec%0d_mispred", i), {31'b0, MispredictE}, {31'b0, |vecs[i].exp_pcsrc});
    end
    idle();

    // Jump overrides a taken branch: no table or counter change
    step();
    drive(1'b1, 1'b1, 1'b1, 3'b000, 32'd7, 32'd7, 32'h100, 1'b0, 1'b0);
    #1;
    check("jalr_pcsrc", {30'b0, PCSrcE}, 32'd2);
    step();
    idle();
    #1;
    check("jalr_predict", {31'b0, PredictTakenD}, 32'd0);
    check("jalr_bcount", {16'b0, BranchCount}, 32'd6);
    check("jalr_mcount", {16'b0, MispredictCount}, 32'd3);

    // Taken branch held by a 3-cycle stall, then released
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd7, 32'd7, 32'h100, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_pcsrc", {30'b0, PCSrcE}, 32'd0);
      step();
      check("stall_predict", {31'b0, PredictTakenD}, 32'd0);
      check("stall_bcount", {16'b0, BranchCount}, 32'd6);
    end
    StallE = 1'b0;
    #1;
    check("unstall_pcsrc", {30'b0, PCSrcE}, 32'd1);
    step();
    idle();
    #1;
    check("unstall_predict", {31'b0, PredictTakenD}, 32'd1);
    check("unstall_bcount", {16'b0, BranchCount}, 32'd7);
    check("unstall_mcount", {16'b0, MispredictCount}, 32'd4);

    // Same-index read during update shows the old value
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd1, 32'd2, 32'h100, 1'b1, 1'b0);
    #1;
    check("rw_pcsrc", {30'b0, PCSrcE}, 32'd3);
    check("rw_predict_pre", {31'b0, PredictTakenD}, 32'd1);
    step();
    idle();
    #1;
    check("rw_predict_post", {31'b0, PredictTakenD}, 32'd0);

    // 20 mispredicting branches at index 1 (PCE=0x204)
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd9, 32'd9, 32'h204, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    idle();
    #1;
    check("sat4_bcount", {28'b0, BranchCount4}, 32'd15);
    check("sat4_mcount", {28'b0, MispredictCount4}, 32'd15);
    check("sat16_bcount", {16'b0, BranchCount}, 32'd28);
    check("sat16_mcount", {16'b0, MispredictCount}, 32'd25);
    PCD = 32'h204;
    #1;
    check("sat_idx1_predict", {31'b0, PredictTakenD}, 32'd1);

    // Reset asserted during an update cycle
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd9, 32'd9, 32'h204, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    #1;
    check("rstupd_bcount", {16'b0, BranchCount}, 32'd0);
    check("rstupd_mcount", {16'b0, MispredictCount}, 32'd0);
    check("rstupd_bcount4", {28'b0, BranchCount4}, 32'd0);
    check("rstupd_mcount4", {28'b0, MispredictCount4}, 32'd0);
    check("rstupd_predict", {31'b0, PredictTakenD}, 32'd0);

    // One taken update from the reset value 01 must flip the prediction
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd9, 32'd9, 32'h204, 1'b0, 1'b0);
    step();
    idle();
    #1;
    check("rst01_predict", {31'b0, PredictTakenD}, 32'd1);
    PCD = 32'h100;
    #1;
    check("rst01_other", {31'b0, PredictTakenD}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
